// File: rtl/bsg_fifo_pkg.sv
// bsg_fifo_pkg: shared pointer wrap helper and count sizing for the small counted FIFO.
package bsg_fifo_pkg;
    localparam int unsigned els_default_lp = 4;

    function automatic int unsigned count_width(input int unsigned els);
        return $clog2(els + 1);
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
        return (p == n - 32'd1) ? 32'd0 : p + 32'd1;
    endfunction

    typedef logic [count_width(els_default_lp)-1:0] count_t;
endpackage

// File: rtl/bsg_fifo_occ_counter.sv
// bsg_fifo_occ_counter: up/down occupancy counter saturating at 0 and max_val_p.
// Optional BSG_FIFO_SIM_CHECKS_EN adds a simulation-only overflow check.
module bsg_fifo_occ_counter
    import bsg_fifo_pkg::*;
#(
    parameter int unsigned max_val_p  = 4,
    parameter int unsigned init_val_p = 0,
    parameter int unsigned max_step_p = 1,
    localparam int unsigned width_lp  = count_width(max_val_p)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o
);
    logic [width_lp-1:0] r_count;
    logic                w_inc;
    logic                w_dec;

    assign w_inc   = up_i & ~down_i & (r_count != width_lp'(max_val_p));
    assign w_dec   = down_i & ~up_i & (r_count != '0);
    assign count_o = r_count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_count <= width_lp'(init_val_p);
        else if (w_inc)
            r_count <= r_count + width_lp'(max_step_p);
        else if (w_dec)
            r_count <= r_count - width_lp'(max_step_p);
    end

`ifdef BSG_FIFO_SIM_CHECKS_EN
    always @(posedge clk_i)
        if (reset_n_i && (32'(r_count) > max_val_p))
            $error("bsg_fifo_occ_counter: count %0d exceeds %0d", r_count, max_val_p);
`endif
endmodule

// File: rtl/bsg_fifo_1r1w_small_counted.sv
// bsg_fifo_1r1w_small_counted: small 1r1w FIFO, valid/ready in, valid/yumi out, with occupancy/vacancy counts.
// Optional BSG_FIFO_SIM_CHECKS_EN compiles in simulation-only protocol checks.
module bsg_fifo_1r1w_small_counted
    import bsg_fifo_pkg::*;
#(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 4,
    localparam int unsigned ptr_width_lp  = count_width(els_p),
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic [width_p-1:0]      data_i,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    yumi_i,
    output logic [ptr_width_lp-1:0] occupancy_o,
    output logic [ptr_width_lp-1:0] vacancy_o
);
    logic [width_p-1:0]       r_mem [els_p];
    logic [addr_width_lp-1:0] r_wr_ptr;
    logic [addr_width_lp-1:0] r_rd_ptr;
    logic [ptr_width_lp-1:0]  w_count;
    logic                     w_enq;
    logic                     w_deq;

    // yumi without valid data is ignored, so it never reaches pointers or count
    assign w_enq = v_i & ready_o;
    assign w_deq = yumi_i & v_o;

    always_ff @(posedge clk_i)
        if (w_enq)
            r_mem[r_wr_ptr] <= data_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq)
                r_wr_ptr <= addr_width_lp'(wrap_inc(32'(r_wr_ptr), els_p));
            if (w_deq)
                r_rd_ptr <= addr_width_lp'(wrap_inc(32'(r_rd_ptr), els_p));
        end
    end

    bsg_fifo_occ_counter #(
        .max_val_p (els_p),
        .init_val_p(0),
        .max_step_p(1)
    ) u_occ (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .up_i     (w_enq),
        .down_i   (w_deq),
        .count_o  (w_count)
    );

    assign ready_o     = (w_count != ptr_width_lp'(els_p));
    assign v_o         = (w_count != '0);
    assign data_o      = r_mem[r_rd_ptr];
    assign occupancy_o = w_count;
    assign vacancy_o   = ptr_width_lp'(els_p) - w_count;

`ifdef BSG_FIFO_SIM_CHECKS_EN
    if (els_p < 2) begin : g_bad_els
        initial $fatal(1, "bsg_fifo_1r1w_small_counted: els_p must be >= 2");
    end
    always @(posedge clk_i)
        if (reset_n_i && yumi_i && !v_o)
            $error("bsg_fifo_1r1w_small_counted: yumi_i while empty");
`endif
endmodule

// File: tb/tb_bsg_fifo_1r1w_small_counted.sv
// tb_bsg_fifo_1r1w_small_counted: directed checks of the counted FIFO with width 32, 4 entries.
module tb_bsg_fifo_1r1w_small_counted;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        v_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        v_o;
    logic [31:0] data_o;
    logic        yumi_i;
    logic [2:0]  occupancy_o;
    logic [2:0]  vacancy_o;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    bsg_fifo_1r1w_small_counted #(.width_p(32), .els_p(4)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .v_o        (v_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .occupancy_o(occupancy_o),
        .vacancy_o  (vacancy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic rdy, input logic vo, input logic [2:0] occ);
        chk({tag, ".ready"}, 32'(ready_o), 32'(rdy));
        chk({tag, ".v_o"}, 32'(v_o), 32'(vo));
        chk({tag, ".occ"}, 32'(occupancy_o), 32'(occ));
        chk({tag, ".vac"}, 32'(vacancy_o), 32'(3'd4 - occ));
    endtask

    initial begin
        reset_n = 1'b0;
        v_i = 1'b0;
        yumi_i = 1'b0;
        data_i = '0;
        #1;
        chk_state("in_reset", 1'b1, 1'b0, 3'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk_state("idle", 1'b1, 1'b0, 3'd0);

        // fill with A,B,C,D
        v_i = 1'b1;
        data_i = 32'hA;
        step();
        chk_state("fill1", 1'b1, 1'b1, 3'd1);
        chk("fill1.data", data_o, 32'hA);
        data_i = 32'hB;
        step();
        data_i = 32'hC;
        step();
        data_i = 32'hD;
        step();
        chk_state("full", 1'b0, 1'b1, 3'd4);
        chk("full.data", data_o, 32'hA);

        // full: hold E, pulse yumi
        data_i = 32'hE;
        yumi_i = 1'b1;
        chk("full_yumi.ready", 32'(ready_o), 32'd0);
        step();
        yumi_i = 1'b0;
        chk_state("after_pop", 1'b1, 1'b1, 3'd3);
        chk("after_pop.data", data_o, 32'hB);
        step();
        v_i = 1'b0;
        chk_state("refull", 1'b0, 1'b1, 3'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), data_o, 32'hB + 32'(i));
            yumi_i = 1'b1;
            step();
        end
        yumi_i = 1'b0;
        chk_state("drained", 1'b1, 1'b0, 3'd0);

        // one stored, then simultaneous push/pop
        v_i = 1'b1;
        data_i = 32'h100;
        step();
        for (int i = 0; i < 10; i++) begin
            data_i = 32'h200 + 32'(i);
            yumi_i = 1'b1;
            chk($sformatf("pp%0d.data", i), data_o, (i == 0) ? 32'h100 : 32'h200 + 32'(i - 1));
            step();
            chk($sformatf("pp%0d.occ", i), 32'(occupancy_o), 32'd1);
        end
        v_i = 1'b0;
        yumi_i = 1'b0;
        chk("pp_end.data", data_o, 32'h209);
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        chk_state("pp_empty", 1'b1, 1'b0, 3'd0);

        // reset mid-write
        v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = 32'h31 + 32'(i);
            step();
        end
        chk("pre_rst.occ", 32'(occupancy_o), 32'd3);
        data_i = 32'h34;
        reset_n = 1'b0;
        #1;
        chk_state("mid_rst", 1'b1, 1'b0, 3'd0);
        step();
        reset_n = 1'b1;
        data_i = 32'h55;
        step();
        v_i = 1'b0;
        chk_state("post_rst", 1'b1, 1'b1, 3'd1);
        chk("post_rst.data", data_o, 32'h55);
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        chk_state("post_rst_pop", 1'b1, 1'b0, 3'd0);

        // yumi while empty must be ignored
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        chk_state("bad_yumi", 1'b1, 1'b0, 3'd0);
        v_i = 1'b1;
        data_i = 32'h66;
        step();
        v_i = 1'b0;
        chk_state("bad_yumi_wr", 1'b1, 1'b1, 3'd1);
        chk("bad_yumi_wr.data", data_o, 32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
